// File: rtl/nibble_serial_alu_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// nibble_serial_alu_ctrl
//
// Runs a WIDTH-bit ALU operation through one shared 4-bit 181-style ALU slice.
// It processes one nibble per clock, least significant nibble first. The
// active-low carry ripples from one nibble to the next through a register.
// The result is built up in a working register and copied to the output
// registers when the operation completes.
//
// Parameters
//   WIDTH     operand/result width; a multiple of 4, at least 8
//
// Ports
//   clk       clock; all state changes happen on the rising edge
//   rst_n     synchronous reset, active low
//   start     request pulse; accepted only in IDLE
//   abort     (only when NSAC_ABORT_EN is defined) drops RUN/DONE back to IDLE
//   op_s      function select, latched and driven to the slice S inputs
//   op_m      mode: 1 = logic, 0 = arithmetic
//   cin_n     active-low carry-in for nibble 0
//   a, b      operands, sampled when start is accepted
//   busy      high in RUN and DONE
//   done      one-cycle completion pulse
//   result    last completed result, held until the next completion
//   cout_n    active-low carry-out of the top nibble of the last completed op
//   a_eq_b    AND of the slice A=B output over all nibbles of the last op
//   alu_a/b   current operand nibbles to the slice
//   alu_s/m   latched function select and mode to the slice
//   alu_ci_n  carry-in to the slice
//   alu_f     slice F output
//   alu_co_n  slice carry-out, active low
//   alu_aeqb  slice A=B output
//
// Optional feature macro: NSAC_ABORT_EN (adds the abort input).
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting for start; slice inputs hold their last values
// ST_RUN  | nibble k is on the slice; its F/co_n are captured at the edge
// ST_DONE | done pulse; result/cout_n/a_eq_b already hold the new values
// -----------------------------------------------------------------------------
module nibble_serial_alu_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef NSAC_ABORT_EN
    input  logic             abort,
`endif
    input  logic [3:0]       op_s,
    input  logic             op_m,
    input  logic             cin_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout_n,
    output logic             a_eq_b,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [3:0]       alu_s,
    output logic             alu_m,
    output logic             alu_ci_n,
    input  logic [3:0]       alu_f,
    input  logic             alu_co_n,
    input  logic             alu_aeqb
);

    localparam int NIB = WIDTH / 4;
    localparam int K_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(NIB - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] work;
    logic [K_W-1:0]   k;
    logic             cin_reg;
    logic             carry_r;
    logic             eq_acc;
    logic             ci_last;
    logic             abort_hit;

`ifdef NSAC_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    // k is not advanced on the last nibble. It stays at the top nibble through
    // DONE and IDLE, so alu_a/alu_b keep showing the last values driven to the
    // slice until the next operation starts.
    assign alu_a = a_reg[4*int'(k) +: 4];
    assign alu_b = b_reg[4*int'(k) +: 4];

    // Outside RUN the carry register has already taken the final carry-out.
    // Use the copy of the last driven carry-in instead, so alu_ci_n holds.
    always_comb begin
        alu_ci_n = ci_last;
        if (state == ST_RUN) begin
            if ((k == '0) || alu_m)
                alu_ci_n = cin_reg;
            else
                alu_ci_n = carry_r;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            cout_n  <= 1'b1;
            a_eq_b  <= 1'b0;
            k       <= '0;
            carry_r <= 1'b1;
            eq_acc  <= 1'b1;
            work    <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            alu_s   <= '0;
            alu_m   <= 1'b0;
            cin_reg <= 1'b1;
            ci_last <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_reg   <= a;
                        b_reg   <= b;
                        alu_s   <= op_s;
                        alu_m   <= op_m;
                        cin_reg <= cin_n;
                        carry_r <= cin_n;
                        eq_acc  <= 1'b1;
                        k       <= '0;
                        busy    <= 1'b1;
                        state   <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    if (abort_hit) begin
                        // Only the working registers have changed so far, so
                        // the outputs keep the previous completed operation.
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        work[4*int'(k) +: 4] <= alu_f;
                        carry_r <= alu_co_n;
                        eq_acc  <= eq_acc & alu_aeqb;
                        ci_last <= alu_ci_n;
                        if (k == K_LAST) begin
                            // The last nibble is the top one. It goes straight
                            // into the output register together with the
                            // lower nibbles already collected.
                            result <= {alu_f, work[WIDTH-5:0]};
                            cout_n <= alu_co_n;
                            a_eq_b <= eq_acc & alu_aeqb;
                            done   <= 1'b1;
                            state  <= ST_DONE;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_alu_ctrl.sv
`timescale 1ns/1ps
module tb_nibble_serial_alu_ctrl;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
`ifdef NSAC_ABORT_EN
    logic              abort = 1'b0;
`endif
    logic [3:0]        op_s = '0;
    logic              op_m = 1'b0;
    logic              cin_n = 1'b1;
    logic [WIDTH-1:0]  a = '0;
    logic [WIDTH-1:0]  b = '0;
    logic              busy, done, cout_n, a_eq_b;
    logic [WIDTH-1:0]  result;
    logic [3:0]        alu_a, alu_b, alu_s, alu_f;
    logic              alu_m, alu_ci_n, alu_co_n, alu_aeqb;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nibble_serial_alu_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
`ifdef NSAC_ABORT_EN
        .abort    (abort),
`endif
        .op_s     (op_s),
        .op_m     (op_m),
        .cin_n    (cin_n),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout_n   (cout_n),
        .a_eq_b   (a_eq_b),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_s    (alu_s),
        .alu_m    (alu_m),
        .alu_ci_n (alu_ci_n),
        .alu_f    (alu_f),
        .alu_co_n (alu_co_n),
        .alu_aeqb (alu_aeqb)
    );

    // 181-style slice, active-high data: arithmetic F = t1 + t2 + carry,
    // logic F = ~(t1 ^ t2); A=B is high when F is all ones.
    logic [3:0] st1, st2;
    logic [4:0] ssum;
    always_comb begin
        st1      = alu_a | (alu_b & {4{alu_s[0]}}) | (~alu_b & {4{alu_s[1]}});
        st2      = (alu_a & alu_b & {4{alu_s[3]}}) | (alu_a & ~alu_b & {4{alu_s[2]}});
        ssum     = {1'b0, st1} + {1'b0, st2} + {4'd0, ~alu_ci_n};
        alu_f    = alu_m ? ~(st1 ^ st2) : ssum[3:0];
        alu_co_n = ~ssum[4];
        alu_aeqb = &alu_f;
    end

    // Word-level reference: {cout_n, a_eq_b, result}
    function automatic logic [WIDTH+1:0] ref_alu(input logic [WIDTH-1:0] ra, input logic [WIDTH-1:0] rb,
                                                 input logic [3:0] rs, input logic rm, input logic rc);
        logic [WIDTH-1:0] t1, t2, f;
        logic [WIDTH:0]   sum;
        t1  = ra | (rb & {WIDTH{rs[0]}}) | (~rb & {WIDTH{rs[1]}});
        t2  = (ra & rb & {WIDTH{rs[3]}}) | (ra & ~rb & {WIDTH{rs[2]}});
        sum = {1'b0, t1} + {1'b0, t2} + {{WIDTH{1'b0}}, ~rc};
        f   = rm ? ~(t1 ^ t2) : sum[WIDTH-1:0];
        return {~sum[WIDTH], &f, f};
    endfunction

    // Expected carry-in seen by each nibble: the inverted carry out of the
    // lower 4k bits of the full-width sum (or cin_n for nibble 0 / logic mode).
    function automatic logic [NIB-1:0] ref_ci(input logic [WIDTH-1:0] ra, input logic [WIDTH-1:0] rb,
                                              input logic [3:0] rs, input logic rm, input logic rc);
        logic [WIDTH-1:0] t1, t2;
        logic [WIDTH:0]   mask, s;
        logic [NIB-1:0]   ci;
        t1 = ra | (rb & {WIDTH{rs[0]}}) | (~rb & {WIDTH{rs[1]}});
        t2 = (ra & rb & {WIDTH{rs[3]}}) | (ra & ~rb & {WIDTH{rs[2]}});
        for (int n = 0; n < NIB; n++) begin
            if (n == 0 || rm) begin
                ci[n] = rc;
            end else begin
                mask  = ({{WIDTH{1'b0}}, 1'b1} << (4 * n)) - 1'b1;
                s     = ({1'b0, t1} & mask) + ({1'b0, t2} & mask) + {{WIDTH{1'b0}}, ~rc};
                ci[n] = ~s[4 * n];
            end
        end
        return ci;
    endfunction

    // Issues one operation from IDLE and returns what was observed; leaves the
    // DUT one cycle after done (IDLE). Scrambles operand inputs after start.
    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tbv,
                          input logic [3:0] ts, input logic tm, input logic tc,
                          output logic [WIDTH-1:0] res, output logic co, output logic eq,
                          output int cyc, output logic [NIB-1:0] ci_seen);
        a = ta; b = tbv; op_s = ts; op_m = tm; cin_n = tc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = WIDTH'($urandom); b = WIDTH'($urandom);
        op_s = 4'($urandom); op_m = 1'($urandom); cin_n = 1'($urandom);
        cyc = 1;
        ci_seen = 'x;
        while (!done && cyc < 20) begin
            if (cyc <= NIB) ci_seen[cyc-1] = alu_ci_n;
            @(posedge clk); #1;
            cyc++;
        end
        res = result; co = cout_n; eq = a_eq_b;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0)   begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0)   begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (result !== '0)   begin failures++; $display("FAIL reset_result got=%h exp=0000", result); end
        checks++; if (cout_n !== 1'b1) begin failures++; $display("FAIL reset_cout_n got=%b exp=1", cout_n); end
        checks++; if (a_eq_b !== 1'b0) begin failures++; $display("FAIL reset_a_eq_b got=%b exp=0", a_eq_b); end
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        logic [WIDTH-1:0] res; logic co, eq; int cyc; logic [NIB-1:0] ci;
        run_op(16'h1234, 16'h0FCD, 4'b1001, 1'b0, 1'b1, res, co, eq, cyc, ci);
        checks++; if (res !== 16'h2201) begin failures++; $display("FAIL add_result got=%h exp=2201", res); end
        checks++; if (co !== 1'b1)      begin failures++; $display("FAIL add_cout_n got=%b exp=1", co); end
        checks++; if (cyc !== NIB + 1)  begin failures++; $display("FAIL add_latency got=%0d exp=%0d", cyc, NIB + 1); end
    endtask

    task automatic test_carry_ripple();
        logic [WIDTH-1:0] res; logic co, eq; int cyc; logic [NIB-1:0] ci;
        run_op(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1, res, co, eq, cyc, ci);
        checks++; if (res !== 16'h0000) begin failures++; $display("FAIL ripple_result got=%h exp=0000", res); end
        checks++; if (co !== 1'b0)      begin failures++; $display("FAIL ripple_cout_n got=%b exp=0", co); end
        checks++; if (ci !== 4'b0001)   begin failures++; $display("FAIL ripple_ci_n got=%b exp=0001", ci); end
    endtask

    task automatic test_sub_eq();
        logic [WIDTH-1:0] res; logic co, eq; int cyc; logic [NIB-1:0] ci;
        run_op(16'h5555, 16'h5555, 4'b0110, 1'b0, 1'b1, res, co, eq, cyc, ci);
        checks++; if (res !== 16'hFFFF) begin failures++; $display("FAIL sub_eq_result got=%h exp=ffff", res); end
        checks++; if (eq !== 1'b1)      begin failures++; $display("FAIL sub_eq_a_eq_b got=%b exp=1", eq); end
        run_op(16'h5555, 16'h5554, 4'b0110, 1'b0, 1'b1, res, co, eq, cyc, ci);
        checks++; if (res !== 16'h0000) begin failures++; $display("FAIL sub_ne_result got=%h exp=0000", res); end
        checks++; if (eq !== 1'b0)      begin failures++; $display("FAIL sub_ne_a_eq_b got=%b exp=0", eq); end
    endtask

    task automatic test_logic_xor();
        logic [WIDTH-1:0] res; logic co, eq; int cyc; logic [NIB-1:0] ci;
        run_op(16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b0, res, co, eq, cyc, ci);
        checks++; if (res !== 16'h0FF0) begin failures++; $display("FAIL xor_result got=%h exp=0ff0", res); end
        checks++; if (ci !== 4'b0000)   begin failures++; $display("FAIL xor_ci_n got=%b exp=0000", ci); end
    endtask

    task automatic test_ignore_start();
        int dcount;
        logic [WIDTH-1:0] r1;
        dcount = 0;
        r1 = 'x;
        a = 16'h1111; b = 16'h2222; op_s = 4'b1001; op_m = 1'b0; cin_n = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c < 15; c++) begin
            start = 1'b0;
            if (c == 2) begin
                start = 1'b1; a = 16'hAAAA; b = 16'h5555; op_s = 4'h0; cin_n = 1'b0;
            end
            if (done) begin
                dcount++; r1 = result; start = 1'b1;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        checks++; if (dcount !== 1)     begin failures++; $display("FAIL ignore_done_count got=%0d exp=1", dcount); end
        checks++; if (r1 !== 16'h3333)  begin failures++; $display("FAIL ignore_result got=%h exp=3333", r1); end
        checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL ignore_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] res; logic co, eq; int cyc; logic [NIB-1:0] ci;
        run_op(16'h0F0F, 16'h0101, 4'b1001, 1'b0, 1'b0, res, co, eq, cyc, ci);
        checks++; if (res !== 16'h1011) begin failures++; $display("FAIL b2b_first got=%h exp=1011", res); end
        checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL b2b_idle_busy got=%b exp=0", busy); end
        run_op(16'h8000, 16'h8000, 4'b1001, 1'b0, 1'b1, res, co, eq, cyc, ci);
        checks++; if (res !== 16'h0000) begin failures++; $display("FAIL b2b_second got=%h exp=0000", res); end
        checks++; if (co !== 1'b0)      begin failures++; $display("FAIL b2b_second_cout_n got=%b exp=0", co); end
        checks++; if (cyc !== NIB + 1)  begin failures++; $display("FAIL b2b_latency got=%0d exp=%0d", cyc, NIB + 1); end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] ra, rb, res;
        logic [3:0]       rs;
        logic             rm, rc, co, eq;
        logic [WIDTH+1:0] exp;
        logic [NIB-1:0]   ci, exp_ci;
        int               cyc;
        for (int i = 0; i < 40; i++) begin
            ra = WIDTH'($urandom); rb = WIDTH'($urandom);
            rs = 4'($urandom); rm = 1'($urandom); rc = 1'($urandom);
            if (i % 8 == 0) rb = ra;
            exp    = ref_alu(ra, rb, rs, rm, rc);
            exp_ci = ref_ci(ra, rb, rs, rm, rc);
            run_op(ra, rb, rs, rm, rc, res, co, eq, cyc, ci);
            checks++; if (res !== exp[WIDTH-1:0]) begin failures++; $display("FAIL rand_result i=%0d got=%h exp=%h", i, res, exp[WIDTH-1:0]); end
            checks++; if (eq !== exp[WIDTH])      begin failures++; $display("FAIL rand_a_eq_b i=%0d got=%b exp=%b", i, eq, exp[WIDTH]); end
            checks++; if (ci !== exp_ci)          begin failures++; $display("FAIL rand_ci_n i=%0d got=%b exp=%b", i, ci, exp_ci); end
            checks++; if (cyc !== NIB + 1)        begin failures++; $display("FAIL rand_latency i=%0d got=%0d exp=%0d", i, cyc, NIB + 1); end
            if (!rm) begin
                checks++; if (co !== exp[WIDTH+1]) begin failures++; $display("FAIL rand_cout_n i=%0d got=%b exp=%b", i, co, exp[WIDTH+1]); end
            end
        end
    endtask

    task automatic test_reset_midrun();
        logic [WIDTH-1:0] res; logic co, eq; int cyc; logic [NIB-1:0] ci;
        int dcount;
        run_op(16'h1234, 16'h0FCD, 4'b1001, 1'b0, 1'b1, res, co, eq, cyc, ci);
        a = 16'hFFFF; b = 16'hFFFF; op_s = 4'b1001; op_m = 1'b0; cin_n = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0)   begin failures++; $display("FAIL rstrun_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0)   begin failures++; $display("FAIL rstrun_done got=%b exp=0", done); end
        checks++; if (result !== '0)   begin failures++; $display("FAIL rstrun_result got=%h exp=0000", result); end
        checks++; if (cout_n !== 1'b1) begin failures++; $display("FAIL rstrun_cout_n got=%b exp=1", cout_n); end
        rst_n = 1'b1;
        dcount = 0;
        for (int c = 0; c < 8; c++) begin
            if (done) dcount++;
            @(posedge clk); #1;
        end
        checks++; if (dcount !== 0)    begin failures++; $display("FAIL rstrun_no_done got=%0d exp=0", dcount); end
    endtask

`ifdef NSAC_ABORT_EN
    task automatic test_abort();
        logic [WIDTH-1:0] res; logic co, eq; int cyc; logic [NIB-1:0] ci;
        int dcount;
        run_op(16'h1234, 16'h0FCD, 4'b1001, 1'b0, 1'b1, res, co, eq, cyc, ci);
        a = 16'hFFFF; b = 16'h0001; op_s = 4'b1001; op_m = 1'b0; cin_n = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
        checks++; if (result !== 16'h2201) begin failures++; $display("FAIL abort_result got=%h exp=2201", result); end
        checks++; if (cout_n !== 1'b1)     begin failures++; $display("FAIL abort_cout_n got=%b exp=1", cout_n); end
        dcount = 0;
        for (int c = 0; c < 8; c++) begin
            if (done) dcount++;
            @(posedge clk); #1;
        end
        checks++; if (dcount !== 0)        begin failures++; $display("FAIL abort_no_done got=%0d exp=0", dcount); end
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_carry_ripple();
        test_sub_eq();
        test_logic_xor();
        test_ignore_start();
        test_back_to_back();
        test_random();
        test_reset_midrun();
`ifdef NSAC_ABORT_EN
        test_abort();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
